// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings, FSM state type and default word width.
package spi_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for an asynchronous pin plus
// single-cycle rise/fall strobes on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
)(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    // Shift the pin through the synchronizer and remember the last settled level
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint supporting all four modes, MSB-first words,
// back-to-back words per select, everything oversampled on clk.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds the frame_err output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = DEFAULT_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_t        state, next_state;
    logic              sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic              mosi_s;
    logic              cpol_q, cpha_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_tx;
    logic [DATA_W-2:0] shift_rx;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] next_word;
    logic              tx_full;
    logic              miso_q;
    logic              start, abort;
    logic              lead_edge, trail_edge;
    logic              sample_evt, drive_evt;
    logic              word_done, load_word, load_accept;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ss_n),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // mosi goes through the same depth so it lines up with the sclk edge strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Frame state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame entry on select falling, abort on select rising at any bit position
    always_comb begin
        next_state = state;
        start      = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    next_state = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Map synchronized sclk edges onto sample/drive events for the latched mode
    always_comb begin
        lead_edge  = cpol_q ? sclk_fall : sclk_rise;
        trail_edge = cpol_q ? sclk_rise : sclk_fall;
        sample_evt = 1'b0;
        drive_evt  = 1'b0;
        if (state == ACTIVE && !ss_rise) begin
            case ({cpol_q, cpha_q})
                MODE0, MODE2: begin
                    sample_evt = lead_edge;
                    drive_evt  = trail_edge;
                end
                MODE1, MODE3: begin
                    sample_evt = trail_edge;
                    drive_evt  = lead_edge;
                end
                default: begin
                    sample_evt = 1'b0;
                    drive_evt  = 1'b0;
                end
            endcase
        end
    end

    assign word_done   = sample_evt && (bit_cnt == LAST_BIT);
    assign load_word   = start | word_done;
    assign load_accept = tx_load & ~tx_full;
    assign rx_word     = {shift_rx, mosi_s};
    // An empty buffer hands a same-cycle load straight to the shifter
    assign next_word   = tx_full ? tx_buf : (load_accept ? tx_data : IDLE_FILL);

    // TX holding buffer: a word start always empties it, loads only land when empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (load_word) begin
            tx_full <= 1'b0;
        end else if (load_accept) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end
    end

    // Shift datapath: mode latch at entry, sample/drive per edge, reload per word
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            bit_cnt  <= '0;
            shift_tx <= '0;
            shift_rx <= '0;
            miso_q   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start) begin
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                bit_cnt  <= '0;
                miso_q   <= next_word[DATA_W-1];
                shift_tx <= cpha ? next_word : {next_word[DATA_W-2:0], 1'b0};
            end else if (abort) begin
                bit_cnt <= '0;
            end else if (sample_evt) begin
                if (word_done) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    shift_tx <= next_word;
                end else begin
                    shift_rx <= rx_word[DATA_W-2:0];
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end else if (drive_evt) begin
                miso_q   <= shift_tx[DATA_W-1];
                shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // Flag a select release that cuts a word short
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort && (bit_cnt != '0);
        end
    end
`endif

    assign tx_ready = ~tx_full;
    assign busy     = (state == ACTIVE);
    assign miso     = (state == ACTIVE && !ss_rise) ? miso_q : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave with an rx scoreboard.
// Honours SPI_SLAVE_FRAME_ERR_EN when defined.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    wire        miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
    int         frameErrCount = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];

    spi_slave dut (
        .clk       (clk),
        .reset     (reset),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err (frame_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle tx_load pulse
    task automatic applyStimulus(input logic [7:0] data);
        tx_data = data;
        tx_load = 1'b1;
        waitCycles(1);
        tx_load = 1'b0;
    endtask

    task automatic frameStart(input logic mCpol, input logic mCpha);
        cpol = mCpol;
        cpha = mCpha;
        sclk = mCpol;
        waitCycles(8);
        ss_n = 1'b0;
        waitCycles(8);
    endtask

    task automatic frameEnd();
        waitCycles(HALF);
        ss_n = 1'b1;
        waitCycles(8);
    endtask

    // Master side of one word (or a partial word of nbits)
    task automatic spiByte(input logic [7:0] mtx, input int nbits, output logic [7:0] mrx);
        mrx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mtx[7-i];
                waitCycles(HALF);
                sclk = ~cpol;
                mrx  = {mrx[6:0], miso};
                waitCycles(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mtx[7-i];
                waitCycles(HALF);
                sclk = cpol;
                mrx  = {mrx[6:0], miso};
                waitCycles(HALF);
            end
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the next expected word
    always @(negedge clk) begin
        if (rx_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_unexpected actual=%0h required=none", rx_data);
            end else begin
                checkOutput("rx_data", {24'h0, rx_data}, {24'h0, expQ.pop_front()});
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always @(negedge clk) begin
        if (frame_err) frameErrCount++;
    end
`endif

    initial begin
        logic [7:0] got;
        logic [1:0] mode;

        waitCycles(4);
        checkOutput("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
        checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        waitCycles(4);

        $display("[TB] mode 0 single word");
        applyStimulus(8'hA5);
        checkOutput("m0_tx_ready_after_load", {31'h0, tx_ready}, 32'h0);
        expQ.push_back(8'h3C);
        frameStart(1'b0, 1'b0);
        checkOutput("m0_busy", {31'h0, busy}, 32'h1);
        spiByte(8'h3C, 8, got);
        frameEnd();
        checkOutput("m0_master_rx", {24'h0, got}, 32'hA5);
        checkOutput("m0_tx_ready_end", {31'h0, tx_ready}, 32'h1);
        checkOutput("m0_busy_end", {31'h0, busy}, 32'h0);

        $display("[TB] modes 1..3");
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            applyStimulus(8'h96);
            expQ.push_back(8'h5A);
            frameStart(mode[1], mode[0]);
            spiByte(8'h5A, 8, got);
            frameEnd();
            checkOutput($sformatf("m%0d_master_rx", m), {24'h0, got}, 32'h96);
            checkOutput($sformatf("m%0d_tx_ready", m), {31'h0, tx_ready}, 32'h1);
        end

        $display("[TB] two words, one loaded");
        applyStimulus(8'h11);
        expQ.push_back(8'hA1);
        expQ.push_back(8'h7E);
        frameStart(1'b0, 1'b0);
        spiByte(8'hA1, 8, got);
        checkOutput("b2b_first", {24'h0, got}, 32'h11);
        spiByte(8'h7E, 8, got);
        checkOutput("b2b_second", {24'h0, got}, 32'hFF);
        frameEnd();

        $display("[TB] abort after 5 bits");
        frameStart(1'b0, 1'b0);
        spiByte(8'hF0, 5, got);
        frameEnd();
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_rx_data_held", {24'h0, rx_data}, 32'h7E);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checkOutput("abort_frame_err_pulses", frameErrCount, 32'h1);
`endif

        $display("[TB] reset mid-word");
        frameStart(1'b0, 1'b0);
        applyStimulus(8'h77);
        checkOutput("rst_tx_ready_full", {31'h0, tx_ready}, 32'h0);
        spiByte(8'hC3, 4, got);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        checkOutput("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("rst_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        ss_n = 1'b1;
        sclk = 1'b0;
        waitCycles(4);
        reset = 1'b1;
        waitCycles(8);
        expQ.push_back(8'hC3);
        frameStart(1'b0, 1'b0);
        spiByte(8'hC3, 8, got);
        frameEnd();
        checkOutput("rst_frame_master_rx", {24'h0, got}, 32'hFF);

        $display("[TB] load while full is dropped");
        applyStimulus(8'h01);
        checkOutput("drop_tx_ready", {31'h0, tx_ready}, 32'h0);
        applyStimulus(8'h02);
        expQ.push_back(8'h00);
        frameStart(1'b0, 1'b0);
        spiByte(8'h00, 8, got);
        frameEnd();
        checkOutput("drop_first_word", {24'h0, got}, 32'h01);
        expQ.push_back(8'h00);
        frameStart(1'b0, 1'b0);
        spiByte(8'h00, 8, got);
        frameEnd();
        checkOutput("drop_second_word", {24'h0, got}, 32'hFF);

        waitCycles(20);
        checkOutput("scoreboard_empty", expQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
